// File: rtl/rgb_window_3x3_gen.sv
// Streaming 3x3 RGB window generator: two line buffers plus a 3x3 shift register feed the edge detector.
// Optional macro WIN_PROTOCOL_CHECK_EN adds a sticky proto_err output for premature or unqualified pix_sof.
module rgb_window_3x3_gen #(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    parameter int unsigned PIX_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_valid,
    input  logic             pix_sof,
    input  logic [PIX_W-1:0] pix_data,
    output logic [PIX_W-1:0] a,
    output logic [PIX_W-1:0] b,
    output logic [PIX_W-1:0] c,
    output logic [PIX_W-1:0] d,
    output logic [PIX_W-1:0] e,
    output logic [PIX_W-1:0] f,
    output logic [PIX_W-1:0] g,
    output logic [PIX_W-1:0] h,
    output logic [PIX_W-1:0] i,
    output logic             win_valid,
    output logic             en,
    output logic             frame_done,
    output logic             busy
`ifdef WIN_PROTOCOL_CHECK_EN
    ,
    output logic             proto_err
`endif
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d, cur_col;
    logic [ROW_W-1:0] row_q, row_d, cur_row;
    logic             accept, last_pix;
    logic             win_valid_q, win_valid_d;
    logic             en_q;
    logic             frame_done_q, frame_done_d;
    logic             busy_q;
    logic [PIX_W-1:0] top_px, mid_px;
    logic [PIX_W-1:0] win_q [9];

    // lb2 holds row R-2, lb1 holds row R-1, indexed by column
    logic [PIX_W-1:0] lb1 [IMG_W];
    logic [PIX_W-1:0] lb2 [IMG_W];

    // A pixel carrying pix_sof is always (0,0), regardless of the counters
    always_comb begin
        accept   = pix_valid && (pix_sof || (state_q == ACTIVE));
        cur_col  = pix_sof ? '0 : col_q;
        cur_row  = pix_sof ? '0 : row_q;
        last_pix = (cur_row == ROW_W'(IMG_H - 1)) && (cur_col == COL_W'(IMG_W - 1));
        top_px   = lb2[cur_col];
        mid_px   = lb1[cur_col];

        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;

        if (accept) begin
            win_valid_d  = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
            frame_done_d = last_pix;
            if (last_pix) begin
                state_d = IDLE;
                col_d   = '0;
                row_d   = '0;
            end else begin
                state_d = ACTIVE;
                if (cur_col == COL_W'(IMG_W - 1)) begin
                    col_d = '0;
                    row_d = cur_row + ROW_W'(1);
                end else begin
                    col_d = cur_col + COL_W'(1);
                    row_d = cur_row;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            en_q         <= 1'b1;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            for (int k = 0; k < 9; k++) win_q[k] <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            en_q         <= ~win_valid_d;
            frame_done_q <= frame_done_d;
            busy_q       <= (state_d == ACTIVE);
            if (accept) begin
                win_q[0] <= win_q[1];
                win_q[1] <= win_q[2];
                win_q[2] <= top_px;
                win_q[3] <= win_q[4];
                win_q[4] <= win_q[5];
                win_q[5] <= mid_px;
                win_q[6] <= win_q[7];
                win_q[7] <= win_q[8];
                win_q[8] <= pix_data;
            end
        end
    end

    // Line-buffer storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2[cur_col] <= mid_px;
            lb1[cur_col] <= pix_data;
        end
    end

`ifdef WIN_PROTOCOL_CHECK_EN
    logic proto_err_q, proto_err_d;

    always_comb begin
        proto_err_d = proto_err_q | (pix_sof && (!pix_valid || (state_q == ACTIVE)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) proto_err_q <= 1'b0;
        else        proto_err_q <= proto_err_d;
    end

    assign proto_err = proto_err_q;
`endif

    assign a          = win_q[0];
    assign b          = win_q[1];
    assign c          = win_q[2];
    assign d          = win_q[3];
    assign e          = win_q[4];
    assign f          = win_q[5];
    assign g          = win_q[6];
    assign h          = win_q[7];
    assign i          = win_q[8];
    assign win_valid  = win_valid_q;
    assign en         = en_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule
